ext_unit_pipe: RTL



---
 rtl/ext_pkg.sv | 24 ++
 rtl/ext_unit_pipe_core.sv | 50 +++++
 rtl/ext_unit_pipe.sv | 81 ++++++++
 3 files changed

// File: rtl/ext_pkg.sv
// Shared definitions for the width-extension unit: operation codes and the buffer entry layout.
package ext_pkg;

    typedef enum logic [2:0] {
        EXT_SEXT  = 3'd0,
        EXT_ZEXT  = 3'd1,
        EXT_LUI   = 3'd2,
        EXT_BROFF = 3'd3,
        EXT_LB    = 3'd4,
        EXT_LBU   = 3'd5,
        EXT_LH    = 3'd6,
        EXT_LHU   = 3'd7
    } ext_mode_e;

    // Widest datapath the entry can carry; narrower instances zero-fill the
    // upper bits, which are constant and drop out in synthesis.
    localparam int EXT_MAX_W = 128;

    typedef struct packed {
        logic [EXT_MAX_W-1:0] data;
        logic                 misalign;
    } ext_entry_t;

endpackage

// File: rtl/ext_unit_pipe_core.sv
// Combinational extension arithmetic: immediates, LUI, branch offsets, byte/halfword loads.
// Zero latency; no handshake.
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int SEL_W  = 2
) (
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_mode,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_sext;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;

    assign imm      = in_data[IMM_W-1:0];
    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    // Halfword lane ignores in_sel[0]; an odd offset is only flagged.
    assign byte_val = in_data[{in_sel, 3'b000} +: 8];
    assign half_val = in_data[{in_sel[SEL_W-1:1], 4'b0000} +: 16];

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (in_mode)
            EXT_SEXT:  data = imm_sext;
            EXT_ZEXT:  data = DATA_W'(imm);
            EXT_LUI:   data = DATA_W'({imm, {IMM_W{1'b0}}});
            EXT_BROFF: data = imm_sext << 2;
            EXT_LB:    data = {{(DATA_W-8){byte_val[7]}}, byte_val};
            EXT_LBU:   data = DATA_W'(byte_val);
            EXT_LH: begin
                data     = {{(DATA_W-16){half_val[15]}}, half_val};
                misalign = in_sel[0];
            end
            EXT_LHU: begin
                data     = DATA_W'(half_val);
                misalign = in_sel[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ext_unit_pipe.sv
// Registered width-extension unit: result computed at accept and held in a 2-entry output FIFO.
// Latency 1 cycle when empty; in_ready depends only on the registered occupancy, never on out_ready.
module ext_unit_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    localparam int SEL_W = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_mode,
    input  logic [SEL_W-1:0]  in_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misalign
);

    logic [DATA_W-1:0] core_data;
    logic              core_misalign;
    ext_entry_t        mem [2];
    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              push;
    logic              pop;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .SEL_W  (SEL_W)
    ) u_core (
        .in_data  (in_data),
        .in_mode  (in_mode),
        .in_sel   (in_sel),
        .data     (core_data),
        .misalign (core_misalign)
    );

    assign in_ready     = (count != 2'd2);
    assign out_valid    = (count != 2'd0);
    assign push         = in_valid & in_ready;
    assign pop          = out_valid & out_ready;
    assign out_data     = DATA_W'(mem[rd_ptr].data);
    assign out_misalign = mem[rd_ptr].misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            // Pointers rewind too so the next entry lands in slot 0.
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr].data     <= EXT_MAX_W'(core_data);
                mem[wr_ptr].misalign <= core_misalign;
                wr_ptr               <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule
